// File: rtl/mext_pkg.sv
// Shared types and decode helpers for the M-extension sequencer and its datapath.
package mext_pkg;

  typedef enum logic [4:0] {
    ADD    = 5'd0,
    SUB    = 5'd1,
    AND    = 5'd2,
    OR     = 5'd3,
    XOR    = 5'd4,
    SLT    = 5'd5,
    SLTU   = 5'd6,
    SLL    = 5'd7,
    SRL    = 5'd8,
    SRA    = 5'd9,
    LUI    = 5'd10,
    MUL    = 5'd11,
    MULH   = 5'd12,
    MULHSU = 5'd13,
    MULHU  = 5'd14,
    DIV    = 5'd15,
    DIVU   = 5'd16,
    REM    = 5'd17,
    REMU   = 5'd18
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  function automatic logic is_mop(input logic [4:0] op);
    return (op >= 5'd11) && (op <= 5'd18);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op >= 5'd15) && (op <= 5'd18);
  endfunction

endpackage

// File: rtl/mdu_iter_dp.sv
// Radix-2 shift-add multiply / restoring divide datapath on operand magnitudes,
// with the final sign fix and result register.
module mdu_iter_dp
  import mext_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            fix,
  input  logic            byp,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [XLEN-1:0] byp_val,
  output logic [XLEN-1:0] result
);

  logic [2*XLEN-1:0] acc_r;
  logic [XLEN-1:0]   opb_r;
  logic [XLEN-1:0]   res_r;
  alu_op_e           op_r;
  logic              neg_r;

  logic              sgn_a_s, sgn_b_s, neg_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s;
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN+1:0]   div_diff_s;
  logic [2*XLEN-1:0] mul_next_s, div_next_s, neg_prod_s;
  logic [XLEN-1:0]   neg_hi_s, fix_val_s;

  // Operand signedness, magnitudes and result sign decoded at load time
  always_comb begin
    sgn_a_s = src_a[XLEN-1] & ((op == MUL) | (op == MULH) | (op == MULHSU) | (op == DIV) | (op == REM));
    sgn_b_s = src_b[XLEN-1] & ((op == MUL) | (op == MULH) | (op == DIV) | (op == REM));
    mag_a_s = sgn_a_s ? ({XLEN{1'b0}} - src_a) : src_a;
    mag_b_s = sgn_b_s ? ({XLEN{1'b0}} - src_b) : src_b;
    if (op == REM) begin
      neg_s = sgn_a_s;
    end else begin
      neg_s = sgn_a_s ^ sgn_b_s;
    end
  end

  // One iteration: multiply adds into the high half then shifts right;
  // divide shifts left and keeps the trial subtraction when it does not borrow.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
    mul_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
    div_diff_s = {1'b0, acc_r[2*XLEN-1:XLEN-1]} - {2'b00, opb_r};
    if (div_diff_s[XLEN+1]) begin
      div_next_s = {acc_r[2*XLEN-2:0], 1'b0};
    end else begin
      div_next_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
    end
  end

  // Final negate and word select; the low word of the 64-bit negate is also the negated quotient
  always_comb begin
    neg_prod_s = {(2*XLEN){1'b0}} - acc_r;
    neg_hi_s   = {XLEN{1'b0}} - acc_r[2*XLEN-1:XLEN];
    case (op_r)
      MUL:                 fix_val_s = neg_r ? neg_prod_s[XLEN-1:0] : acc_r[XLEN-1:0];
      MULH, MULHSU, MULHU: fix_val_s = neg_r ? neg_prod_s[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
      DIV, DIVU:           fix_val_s = neg_r ? neg_prod_s[XLEN-1:0] : acc_r[XLEN-1:0];
      REM, REMU:           fix_val_s = neg_r ? neg_hi_s : acc_r[2*XLEN-1:XLEN];
      default:             fix_val_s = {XLEN{1'b0}};
    endcase
  end

  // Accumulator, divisor/multiplier and captured op
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r <= {(2*XLEN){1'b0}};
      opb_r <= {XLEN{1'b0}};
      op_r  <= ADD;
      neg_r <= 1'b0;
    end else if (load) begin
      acc_r <= {{XLEN{1'b0}}, mag_a_s};
      opb_r <= mag_b_s;
      op_r  <= op;
      neg_r <= neg_s;
    end else if (step) begin
      acc_r <= is_div(op_r) ? div_next_s : mul_next_s;
    end
  end

  // Result register holds its value between operations
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_r <= {XLEN{1'b0}};
    end else if (fix) begin
      res_r <= fix_val_s;
    end else if (byp) begin
      res_r <= byp_val;
    end
  end

  assign result = res_r;

endmodule

// File: rtl/mdu_sequencer.sv
// Execute-stage M-extension controller: FSM, iteration counter, special-case
// bypass and pipeline stall / result-valid generation.
module mdu_sequencer
  import mext_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      alu_opE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            flushE,
  output logic            stall_m,
  output logic            flagM,
  output logic [XLEN-1:0] result_m,
  output logic            busy
);

  mdu_state_e       state_r, state_n;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r, flag_r;
  logic             start_s, div_zero_s, ovf_s, last_s;
  logic             load_s, step_s, fix_s, byp_s;
  logic [XLEN-1:0]  byp_val_s;
  alu_op_e          op_s;

  assign op_s = alu_op_e'(alu_opE);
  // rst term keeps stall_m low while reset is held even if an M op sits in execute
  assign start_s    = rst & (state_r == IDLE) & is_mop(alu_opE) & ~flushE;
  assign div_zero_s = is_div(alu_opE) & (SrcBE == {XLEN{1'b0}});
  assign ovf_s      = ((op_s == DIV) | (op_s == REM)) & (SrcAE == {1'b1, {(XLEN-1){1'b0}}})
                      & (SrcBE == {XLEN{1'b1}});
  assign last_s     = (cnt_r == CNT_W'(XLEN-1));

  // Special-case result, valid only when a bypass is taken
  always_comb begin
    byp_val_s = {XLEN{1'b0}};
    if (div_zero_s) begin
      byp_val_s = ((op_s == DIV) | (op_s == DIVU)) ? {XLEN{1'b1}} : SrcAE;
    end else if (ovf_s) begin
      byp_val_s = (op_s == DIV) ? {1'b1, {(XLEN-1){1'b0}}} : {XLEN{1'b0}};
    end else begin
      byp_val_s = {XLEN{1'b0}};
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    state_n = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    fix_s   = 1'b0;
    byp_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s & (div_zero_s | ovf_s)) begin
          byp_s   = 1'b1;
          state_n = DONE;
        end else if (start_s) begin
          load_s  = 1'b1;
          state_n = CALC;
        end else begin
          state_n = IDLE;
        end
      end
      CALC: begin
        if (flushE) begin
          state_n = IDLE;
        end else begin
          step_s  = 1'b1;
          state_n = last_s ? FIX : CALC;
        end
      end
      FIX: begin
        if (flushE) begin
          state_n = IDLE;
        end else begin
          fix_s   = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, counter and registered status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      flag_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n == CALC) | (state_n == FIX);
      flag_r  <= (state_n == DONE);
      if (load_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (step_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  mdu_iter_dp #(.XLEN(XLEN)) u_dp (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .step    (step_s),
    .fix     (fix_s),
    .byp     (byp_s),
    .op      (op_s),
    .src_a   (SrcAE),
    .src_b   (SrcBE),
    .byp_val (byp_val_s),
    .result  (result_m)
  );

  assign stall_m = start_s | (busy_r & ~flushE);
  assign busy    = busy_r;
  assign flagM   = flag_r;

endmodule
